// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester/ROM bus bundle for the sprite ROM arbiter
// Purpose: groups the requester handshake, ROM read port and status signals of
//          sprite_rom_arbiter so they travel as one port.
// Signals: req/req_addr/req_len   requester side, one slice per requester
//          gnt/rd_data/rd_valid/done  results returned to the requesters
//          rom_en/rom_addr/rom_data   shared pattern ROM read port
//          busy                       arbiter not idle
// Modports: slave = the arbiter, master = requesters plus ROM.
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12,
  parameter int LEN_W  = 5
);
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [2:0]          gnt;
  logic                rom_en;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_data;
  logic [DATA_W-1:0]   rd_data;
  logic [2:0]          rd_valid;
  logic [2:0]          done;
  logic                busy;

  modport slave (
    input  req, req_addr, req_len, rom_data,
    output gnt, rom_en, rom_addr, rd_data, rd_valid, done, busy
  );

  modport master (
    output req, req_addr, req_len, rom_data,
    input  gnt, rom_en, rom_addr, rd_data, rd_valid, done, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin burst arbiter for the shared pattern ROM
// Purpose: grants the pattern ROM to player 1, player 2 or background fetch in
//          round-robin order, issues the burst addresses, tags returning data
//          to the owner and pulses done when the owner's last word returns.
// Ports:   clock  system clock
//          reset  asynchronous, active-high
//          bus    sprite_rom_arbiter_if.slave (req/req_addr/req_len in,
//                 gnt/rom_en/rom_addr/rd_data/rd_valid/done/busy out, rom_data in)
module sprite_rom_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12,
  parameter int LEN_W   = 5,
  parameter int ROM_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  sprite_rom_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [4:0]          len_q, len_d;
  logic [4:0]          count_q, count_d;
  logic [ROM_LAT-1:0]  sr_q, sr_d;

  logic                any_req;
  logic [1:0]          win;
  logic [1:0]          cand;
  logic [LEN_W-1:0]    raw_len;
  logic [4:0]          win_len;
  logic                rom_en;
  logic                done_now;
  logic [ROM_LAT-1:0]  sr_lower;

  // Round robin: look at last+1, last+2, then last itself.
  always_comb begin
    win     = 2'd0;
    any_req = 1'b0;
    cand    = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last_q) + i) % 3);
      if (!any_req && bus.req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Bursts longer than 16 words are clamped to 16.
  always_comb begin
    raw_len = bus.req_len[int'(win)*LEN_W +: LEN_W];
    win_len = (32'(raw_len) > 32'd16) ? 5'd16 : 5'(raw_len);
  end

  assign rom_en   = (state_q == ISSUE);
  // Everything below the tail of the read pipe is still in flight.
  assign sr_lower = sr_q & ~(ROM_LAT'(1) << (ROM_LAT - 1));
  // Shift in this cycle's strobe; the truncating cast also covers ROM_LAT = 1.
  assign sr_d     = ROM_LAT'({sr_q, rom_en});

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    base_d   = base_q;
    len_d    = len_q;
    count_d  = count_q;
    done_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = 3'b001 << win;
          last_d  = win;
          base_d  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
          len_d   = win_len;
          count_d = 5'd0;
          state_d = (win_len == 5'd0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        count_d = count_q + 5'd1;
        if (count_q == len_q - 5'd1) state_d = DRAIN;
      end
      DRAIN: begin
        // Strobes are contiguous, so the tail word with nothing behind it is the last one.
        if (len_q == 5'd0 || (sr_q[ROM_LAT-1] && sr_lower == '0)) begin
          done_now = 1'b1;
          gnt_d    = 3'b000;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      gnt_q   <= 3'b000;
      base_q  <= '0;
      len_q   <= 5'd0;
      count_q <= 5'd0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rom_en   = rom_en;
  assign bus.rom_addr = rom_en ? (base_q + ADDR_W'(count_q)) : '0;
  assign bus.rd_data  = bus.rom_data;
  assign bus.rd_valid = sr_q[ROM_LAT-1] ? gnt_q : 3'b000;
  assign bus.done     = done_now ? gnt_q : 3'b000;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 12;
  localparam int LEN_W   = 5;
  localparam int ROM_LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ROM_LAT(ROM_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a ^ (a >> 5) ^ 16'h0A5C);
  endfunction

  // ROM model: word for the strobed address appears ROM_LAT cycles later.
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clock) begin
    rom_pipe[0] <= bus.rom_en ? rom_word(bus.rom_addr) : '0;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data = rom_pipe[ROM_LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one burst described by start cycle, owner, base and length;
  // every output is a function of the cycle offset from the grant.
  bit                m_act  = 1'b0;
  int                m_start = 0;
  int                m_owner = 0;
  logic [ADDR_W-1:0] m_base = '0;
  int                m_len  = 0;
  int                m_last = 2;

  task automatic model_check(input logic rst, input logic [2:0] rq,
                             input logic [3*ADDR_W-1:0] ad, input logic [3*LEN_W-1:0] ln);
    int k, m_end, raw, w;
    bit inb, found;
    logic [2:0] e_gnt, e_rv, e_done;
    logic e_en;
    if (rst) begin
      m_act  = 1'b0;
      m_last = 2;
    end
    k     = cyc - m_start;
    m_end = (m_len == 0) ? 1 : m_len + ROM_LAT;
    inb   = m_act && k >= 1 && k <= m_end;
    e_gnt  = inb ? 3'(1 << m_owner) : 3'b000;
    e_en   = m_act && k >= 1 && k <= m_len;
    e_rv   = (m_act && m_len > 0 && k >= 1 + ROM_LAT && k <= m_len + ROM_LAT) ? e_gnt : 3'b000;
    e_done = (m_act && k == m_end) ? e_gnt : 3'b000;
    chk("gnt", 64'(bus.gnt), 64'(e_gnt));
    chk("busy", 64'(bus.busy), 64'(inb));
    chk("rom_en", 64'(bus.rom_en), 64'(e_en));
    if (e_en) chk("rom_addr", 64'(bus.rom_addr), 64'(ADDR_W'(m_base + ADDR_W'(k - 1))));
    chk("rd_valid", 64'(bus.rd_valid), 64'(e_rv));
    if (e_rv != 3'b000)
      chk("rd_data", 64'(bus.rd_data), 64'(rom_word(ADDR_W'(m_base + ADDR_W'(k - 1 - ROM_LAT)))));
    chk("done", 64'(bus.done), 64'(e_done));
    if (!rst && !inb && rq != 3'b000) begin
      found = 1'b0;
      w = 0;
      for (int j = 1; j <= 3; j++) begin
        if (!found && rq[(m_last + j) % 3]) begin
          w = (m_last + j) % 3;
          found = 1'b1;
        end
      end
      raw     = int'(ln[w*LEN_W +: LEN_W]);
      m_act   = 1'b1;
      m_start = cyc;
      m_owner = w;
      m_base  = ad[w*ADDR_W +: ADDR_W];
      m_len   = (raw > 16) ? 16 : raw;
      m_last  = w;
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] rq,
                      input logic [3*ADDR_W-1:0] ad, input logic [3*LEN_W-1:0] ln);
    @(posedge clock);
    #1;
    reset        = rst;
    bus.req      = rq;
    bus.req_addr = ad;
    bus.req_len  = ln;
    #1;
    cyc++;
    model_check(rst, rq, ad, ln);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, '0);
  endtask

  function automatic int oh2idx(input logic [2:0] oh);
    return oh[0] ? 0 : (oh[1] ? 1 : (oh[2] ? 2 : -1));
  endfunction

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [47:0] addr;
    logic [14:0] len;
    logic [2:0]  gnt;
    logic        en;
    logic [15:0] raddr;
    logic [2:0]  rv;
    logic [2:0]  done;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [47:0] addr,
                              input logic [14:0] len, input logic [2:0] gnt, input logic en,
                              input logic [15:0] raddr, input logic [2:0] rv,
                              input logic [2:0] done, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.addr = addr; v.len = len; v.gnt = gnt;
    v.en = en; v.raddr = raddr; v.rv = rv; v.done = done; v.busy = busy;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [47:0] a4;
    logic [14:0] l4;
    logic [2:0]  prev_gnt;
    int          g_owner[$];
    int          g_cyc[$];
    logic [15:0] addrs[$];
    int          strobes, dones, first_own;
    bit          seen1, done_bad;
    logic        rst_r;
    logic [2:0]  rq_r;

    bus.req = 3'b000; bus.req_addr = '0; bus.req_len = '0;

    a4 = {16'h0000, 16'h0000, 16'h0100};
    l4 = {5'd0, 5'd0, 5'd4};
    tbl.push_back(mk(1, 3'b000, 48'h0, 15'h0, 3'b000, 0, 16'h0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(1, 3'b000, 48'h0, 15'h0, 3'b000, 0, 16'h0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 48'h0, 15'h0, 3'b000, 0, 16'h0, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b001, a4, l4, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 1, 16'h0100, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 1, 16'h0101, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 1, 16'h0102, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 1, 16'h0103, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 0, 16'h0000, 3'b001, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b001, 0, 16'h0000, 3'b001, 3'b001, 1));
    tbl.push_back(mk(0, 3'b000, a4, l4, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 48'h0, 15'h0, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 48'h0, 15'h0, 3'b010, 0, 16'h0000, 3'b000, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 48'h0, 15'h0, 3'b000, 0, 16'h0000, 3'b000, 3'b000, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].len);
      chk("tbl_gnt", 64'(bus.gnt), 64'(tbl[i].gnt));
      chk("tbl_rom_en", 64'(bus.rom_en), 64'(tbl[i].en));
      if (tbl[i].en) chk("tbl_rom_addr", 64'(bus.rom_addr), 64'(tbl[i].raddr));
      chk("tbl_rd_valid", 64'(bus.rd_valid), 64'(tbl[i].rv));
      chk("tbl_done", 64'(bus.done), 64'(tbl[i].done));
      chk("tbl_busy", 64'(bus.busy), 64'(tbl[i].busy));
    end

    // Round robin with all three requesting continuously, len 1.
    step(1'b1, 3'b000, '0, '0);
    prev_gnt = 3'b000;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'b111, {16'h3000, 16'h2000, 16'h1000}, {5'd1, 5'd1, 5'd1});
      if (bus.gnt != 3'b000 && prev_gnt == 3'b000) begin
        g_owner.push_back(oh2idx(bus.gnt));
        g_cyc.push_back(cyc);
      end
      prev_gnt = bus.gnt;
    end
    idle(6);
    chk("rr_grants", 64'(g_owner.size() >= 6), 64'(1));
    if (g_owner.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("rr_order", 64'(g_owner[i]), 64'(i % 3));
        if (i > 0) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'(4));
      end
    end

    // Address wrap-around on the background requester.
    step(1'b0, 3'b100, {16'hFFFE, 16'h0, 16'h0}, {5'd4, 5'd0, 5'd0});
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 3'b000, '0, '0);
      if (bus.rom_en) addrs.push_back(bus.rom_addr);
    end
    chk("wrap_count", 64'(addrs.size()), 64'(4));
    if (addrs.size() == 4) begin
      chk("wrap_a0", 64'(addrs[0]), 64'h0000_FFFE);
      chk("wrap_a1", 64'(addrs[1]), 64'h0000_FFFF);
      chk("wrap_a2", 64'(addrs[2]), 64'h0000_0000);
      chk("wrap_a3", 64'(addrs[3]), 64'h0000_0001);
    end

    // len 20 clamped to 16 on player 1, then len 0 on player 2.
    step(1'b1, 3'b000, '0, '0);
    strobes = 0; first_own = -1; seen1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rq_r = (i == 0) ? 3'b011 : (seen1 ? 3'b000 : 3'b010);
      step(1'b0, rq_r, {16'h0, 16'h0500, 16'h0400}, {5'd0, 5'd0, 5'd20});
      if (first_own < 0 && bus.gnt != 3'b000) first_own = oh2idx(bus.gnt);
      if (bus.gnt == 3'b001 && bus.rom_en) strobes++;
      if (bus.gnt == 3'b010) begin
        seen1 = 1'b1;
        chk("len0_done", 64'(bus.done), 64'(3'b010));
        chk("len0_rom_en", 64'(bus.rom_en), 64'(0));
        chk("len0_rd_valid", 64'(bus.rd_valid), 64'(0));
      end
    end
    chk("clamp_first", 64'(first_own), 64'(0));
    chk("clamp_strobes", 64'(strobes), 64'(16));
    chk("len0_granted", 64'(seen1), 64'(1));

    // Reset in cycle 3 of a len-8 burst.
    step(1'b1, 3'b000, '0, '0);
    step(1'b0, 3'b001, {16'h0, 16'h0, 16'h0200}, {5'd2, 5'd2, 5'd8});
    idle(2);
    step(1'b1, 3'b000, '0, '0);
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_rom_en", 64'(bus.rom_en), 64'(0));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    step(1'b1, 3'b000, '0, '0);
    g_owner.delete();
    prev_gnt = 3'b000;
    done_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rq_r = (i == 0) ? 3'b010 : 3'b011;
      step(1'b0, rq_r, {16'h0, 16'h0600, 16'h0700}, {5'd2, 5'd2, 5'd2});
      if (i == 0 && bus.done != 3'b000) done_bad = 1'b1;
      if (bus.gnt != 3'b000 && prev_gnt == 3'b000) g_owner.push_back(oh2idx(bus.gnt));
      prev_gnt = bus.gnt;
    end
    idle(8);
    chk("rst_no_done", 64'(done_bad), 64'(0));
    chk("rst_regrant", 64'(g_owner.size() >= 2), 64'(1));
    if (g_owner.size() >= 2) begin
      chk("rst_first_owner", 64'(g_owner[0]), 64'(1));
      chk("rst_second_owner", 64'(g_owner[1]), 64'(0));
    end

    // req[0] dropped in cycle 2 of a len-8 burst.
    strobes = 0; dones = 0;
    for (int i = 0; i < 16; i++) begin
      rq_r = (i < 2) ? 3'b001 : 3'b000;
      step(1'b0, rq_r, {16'h0, 16'h0, 16'h0300}, {5'd0, 5'd0, 5'd8});
      if (bus.rom_en) strobes++;
      if (bus.done[0]) dones++;
    end
    chk("drop_strobes", 64'(strobes), 64'(8));
    chk("drop_done", 64'(dones), 64'(1));

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst_r = ($urandom_range(0, 199) == 0);
      rq_r  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      step(rst_r, rq_r,
           {16'($urandom), 16'($urandom_range(16'hFFF0, 16'hFFFF)), 16'($urandom)},
           {5'($urandom_range(0, 31)), 5'($urandom_range(0, 20)), 5'($urandom_range(0, 18))});
    end
    idle(24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
